// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and sizing constants for the instruction memory loader
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_BYTES  = 3'd2,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned DEFAULT_DEPTH  = 64;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - big-endian byte-to-word shift register for the loader
module byte_packer
  import imem_loader_pkg::*;
#(
  parameter int unsigned BITSIZE = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               shift_en,
  input  logic [7:0]         byte_in,
  output logic [BITSIZE-1:0] word,
  output logic               word_full
);

  localparam logic [1:0] LAST_INDEX = 2'(BYTES_PER_WORD - 1);

  logic [1:0] index;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word  <= '0;
      index <= 2'd0;
    end else if (clear) begin
      word  <= '0;
      index <= 2'd0;
    end else if (shift_en) begin
      word  <= {word[BITSIZE-9:0], byte_in};
      index <= index + 2'd1;
    end
  end

  // Flags the shift that completes a word so the loader can schedule its write next cycle
  assign word_full = shift_en && (index == LAST_INDEX);

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - fills instruction memory from a length-prefixed big-endian byte stream
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned BITSIZE = 32,
  parameter int unsigned REGSIZE = 64,
  parameter int unsigned DEPTH   = DEFAULT_DEPTH
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               Start,
  input  logic [7:0]         ByteIn,
  input  logic               ByteValid,
  output logic               ByteReady,
  output logic               WriteEnable,
  output logic [REGSIZE-1:0] WriteAddress,
  output logic [BITSIZE-1:0] WriteData,
  output logic               Busy,
  output logic               Done,
  output logic               Error
);

  localparam logic [7:0] DEPTH_COUNT = 8'(DEPTH);

  state_t     state;
  logic [7:0] words_left;
  logic       accept;
  logic       clear_packer;
  logic       shift_en;
  logic       word_full;

  assign accept       = ByteValid && ByteReady;
  assign clear_packer = ((state == ST_IDLE) || (state == ST_DONE)) && Start;
  assign shift_en     = (state == ST_BYTES) && accept;

  byte_packer #(.BITSIZE(BITSIZE)) u_packer (
    .clk      (CLOCK),
    .rst      (RESET),
    .clear    (clear_packer),
    .shift_en (shift_en),
    .byte_in  (ByteIn),
    .word     (WriteData),
    .word_full(word_full)
  );

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state        <= ST_IDLE;
      words_left   <= 8'd0;
      ByteReady    <= 1'b0;
      WriteEnable  <= 1'b0;
      WriteAddress <= '0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      Error        <= 1'b0;
    end else begin
      WriteEnable <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (Start) begin
            state        <= ST_HEADER;
            Done         <= 1'b0;
            Error        <= 1'b0;
            WriteAddress <= '0;
            ByteReady    <= 1'b1;
            Busy         <= 1'b1;
          end
        end
        ST_HEADER: begin
          if (accept) begin
            if (ByteIn == 8'd0) begin
              state     <= ST_DONE;
              ByteReady <= 1'b0;
              Busy      <= 1'b0;
              Done      <= 1'b1;
            end else begin
              state <= ST_BYTES;
              // Oversized loads are clamped; surplus source bytes are simply never accepted
              if ({24'd0, ByteIn} > DEPTH) begin
                Error      <= 1'b1;
                words_left <= DEPTH_COUNT;
              end else begin
                words_left <= ByteIn;
              end
            end
          end
        end
        ST_BYTES: begin
          if (word_full) begin
            state       <= ST_WRITE;
            ByteReady   <= 1'b0;
            WriteEnable <= 1'b1;
          end
        end
        ST_WRITE: begin
          WriteAddress <= WriteAddress + REGSIZE'(1);
          words_left   <= words_left - 8'd1;
          if (words_left == 8'd1) begin
            state <= ST_DONE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end else begin
            state     <= ST_BYTES;
            ByteReady <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          ByteReady <= 1'b0;
          Busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        Start;
  logic [7:0]  ByteIn;
  logic        ByteValid;
  logic        ByteReady;
  logic        WriteEnable;
  logic [63:0] WriteAddress;
  logic [31:0] WriteData;
  logic        Busy;
  logic        Done;
  logic        Error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] wa[$];
  logic [31:0] wd[$];

  imem_loader #(.BITSIZE(32), .REGSIZE(64), .DEPTH(64)) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .Start       (Start),
    .ByteIn      (ByteIn),
    .ByteValid   (ByteValid),
    .ByteReady   (ByteReady),
    .WriteEnable (WriteEnable),
    .WriteAddress(WriteAddress),
    .WriteData   (WriteData),
    .Busy        (Busy),
    .Done        (Done),
    .Error       (Error)
  );

  always #5 CLOCK = ~CLOCK;

  always @(negedge CLOCK) begin
    if (WriteEnable === 1'b1) begin
      wa.push_back(WriteAddress);
      wd.push_back(WriteData);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic acc;
    bit   taken;
    taken = 1'b0;
    ByteValid = 1'b0;
    repeat (gap) @(negedge CLOCK);
    ByteIn    = b;
    ByteValid = 1'b1;
    for (int i = 0; i < 20 && !taken; i++) begin
      acc = ByteReady;
      @(negedge CLOCK);
      if (acc) taken = 1'b1;
    end
    ByteValid = 1'b0;
    if (!taken) check("byte_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input int gapmax, input logic [63:0] addr);
    for (int k = 0; k < 4; k++)
      send_byte(w[31-8*k -: 8], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
    check("we_latency", 64'(WriteEnable), 64'd1);
    check("we_addr", WriteAddress, addr);
    check("we_data", 64'(WriteData), 64'(w));
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(negedge CLOCK);
    Start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_flags"}, 64'({ByteReady, WriteEnable, Busy, Done, Error}), 64'd0);
    check({tag, "_addr"}, WriteAddress, 64'd0);
    check({tag, "_data"}, 64'(WriteData), 64'd0);
  endtask

  function automatic logic [31:0] pat(input int i);
    logic [7:0] a;
    logic [7:0] c;
    a = 8'(i);
    c = 8'(i * 7);
    return {a, 8'h5A, ~a, c};
  endfunction

  initial begin
    int bad;
    RESET = 1'b1;
    Start = 1'b0;
    ByteIn = 8'h00;
    ByteValid = 1'b0;

    // Reset state
    @(negedge CLOCK);
    check_all_zero("reset");
    RESET = 1'b0;
    @(negedge CLOCK);

    // Test 1: N=3 gapless; Start with ByteValid in IDLE must not consume the byte
    Start = 1'b1; ByteValid = 1'b1; ByteIn = 8'd3;
    check("rdy_idle", 64'(ByteReady), 64'd0);
    @(negedge CLOCK);
    Start = 1'b0;
    check("busy_header", 64'({Busy, ByteReady, Done}), 64'b110);
    send_byte(8'd3, 0);
    wa.delete(); wd.delete();
    send_word(32'hF2800020, 0, 64'd0);
    send_word(32'hF2800021, 0, 64'd1);
    send_word(32'h8B010002, 0, 64'd2);
    check("t1_rdy_in_write", 64'(ByteReady), 64'd0);
    @(negedge CLOCK);
    check("t1_done", 64'({Done, Busy, Error}), 64'b100);
    check("t1_addr_final", WriteAddress, 64'd3);
    check("t1_count", 64'(wa.size()), 64'd3);
    check("t1_log0", {wa[0][31:0], wd[0]}, {32'd0, 32'hF2800020});
    check("t1_log2", {wa[2][31:0], wd[2]}, {32'd2, 32'h8B010002});

    // Test 2: N=0 from DONE
    wa.delete(); wd.delete();
    pulse_start();
    check("t2_start_clears", 64'({Done, Busy}), 64'b01);
    send_byte(8'd0, 0);
    check("t2_done", 64'({Done, Busy, ByteReady}), 64'b100);
    @(negedge CLOCK);
    check("t2_no_write", 64'(wa.size()), 64'd0);

    // Test 3: N=2 with random ByteValid gaps
    pulse_start();
    send_byte(8'd2, 3);
    send_word(32'h12345678, 5, 64'd0);
    send_word(32'h9ABCDEF0, 5, 64'd1);
    @(negedge CLOCK);
    check("t3_done", 64'(Done), 64'd1);
    check("t3_count", 64'(wa.size()), 64'd2);
    check("t3_log1", {wa[1][31:0], wd[1]}, {32'd1, 32'h9ABCDEF0});

    // Test 4: N=70 clamps to 64 words
    wa.delete(); wd.delete();
    pulse_start();
    send_byte(8'd70, 0);
    check("t4_error", 64'(Error), 64'd1);
    for (int i = 0; i < 64; i++) send_word(pat(i), 0, 64'(i));
    check("t4_rdy_after_last", 64'(ByteReady), 64'd0);
    ByteIn = 8'hEE; ByteValid = 1'b1;
    @(negedge CLOCK);
    check("t4_done", 64'({Done, Busy, Error, ByteReady}), 64'b1010);
    check("t4_addr_final", WriteAddress, 64'd64);
    @(negedge CLOCK);
    ByteValid = 1'b0;
    check("t4_count", 64'(wa.size()), 64'd64);
    bad = 0;
    for (int i = 0; i < 64; i++)
      if (wa[i] !== 64'(i) || wd[i] !== pat(i)) bad++;
    check("t4_log", 64'(bad), 64'd0);

    // Test 6: Start in DONE clears Done/Error; Start while Busy ignored
    wa.delete(); wd.delete();
    pulse_start();
    check("t6_cleared", 64'({Done, Error, Busy}), 64'b001);
    pulse_start();
    send_byte(8'd1, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    pulse_start();
    check("t6_busy_kept", 64'(Busy), 64'd1);
    send_byte(8'h03, 0);
    send_byte(8'h04, 0);
    check("t6_write", {WriteEnable, WriteAddress[31:0], WriteData}, {1'b1, 32'd0, 32'h01020304});
    @(negedge CLOCK);
    check("t6_done", 64'({Done, Error, Busy}), 64'b100);
    check("t6_count", 64'(wa.size()), 64'd1);

    // Test 5: reset in the middle of the second word
    wa.delete(); wd.delete();
    pulse_start();
    send_byte(8'd2, 0);
    send_word(32'hCAFEF00D, 0, 64'd0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    RESET = 1'b1;
    #1;
    check_all_zero("t5_async");
    @(negedge CLOCK);
    RESET = 1'b0;
    @(negedge CLOCK);
    check("t5_one_write", 64'(wa.size()), 64'd1);
    pulse_start();
    send_byte(8'd1, 0);
    send_word(32'hDEADBEEF, 0, 64'd0);
    @(negedge CLOCK);
    check("t5_restart_done", 64'({Done, Error, Busy}), 64'b100);
    check("t5_count", 64'(wa.size()), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
